local_mem_arbiter: RTL and testbench
====================================

Name: local_mem_arbiter

Overview:
Shares one single-port local memory (word-addressed, 1-cycle read latency) between NUM_PORTS requesters, e.g. instruction fetch, load/store sub-unit, debug/DMA.
- Round-robin arbitration each cycle.
- Lock mechanism so a requester can hold the memory across a read-modify-write sequence.
- Routes returned read data back to the requester that issued the read.
- Sits between the requester sub-units and the local_memory_interface master.

Parameters:
NUM_PORTS, 2, number of requesters (2..4)
ADDR_W, 30, word address width
MAX_LOCK_CYCLES, 16, lock timeout in cycles (used only with LOCAL_MEM_ARB_LOCK_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset (asserted at 0)
req  input  NUM_PORTS  request valid per port
lock  input  NUM_PORTS  hold grant after this access
we  input  NUM_PORTS  1 = write, 0 = read
addr  input  NUM_PORTS*ADDR_W  word addresses, port i at [i*ADDR_W +: ADDR_W]
be  input  NUM_PORTS*4  byte enables per port
wdata  input  NUM_PORTS*32  write data per port
gnt  output  NUM_PORTS  one-hot grant; request accepted when req[i]&&gnt[i]
rvalid  output  NUM_PORTS  read data valid for port i
rdata  output  32  read data, shared by all ports
lock_abort  output  NUM_PORTS  1-cycle pulse: lock forcibly released
mem_en  output  1  memory enable
mem_addr  output  ADDR_W  memory word address
mem_be  output  4  memory byte enables; 0 = read
mem_data_in  output  32  memory write data
mem_data_out  input  32  memory read data, valid 1 cycle after a read enable

Behaviour:
Grant generation (combinational from req, rr_ptr, lock state):
- gnt[i] only when req[i]=1; at most one bit set; gnt=0 when no req.
- Unlocked: first requesting port scanning from rr_ptr upward, wrapping modulo NUM_PORTS.
- Locked: only lock_owner may be granted; others see gnt=0. If the owner does not request, the memory idles.

Memory side:
- mem_en = |(req&gnt).
- mem_addr, mem_be, mem_data_in are muxed from the granted port.
- mem_be = we ? be : 4'h0.
- Idle (no grant): mem_en=0, mem_be=0, mem_addr and mem_data_in = port 0 values.

Round-robin pointer:
- rr_ptr (reset 0) <= (k+1) mod NUM_PORTS after an accepted access by port k.
- Not updated while locked.

Lock handling:
- Accepted access with lock[k]=1 sets locked=1, lock_owner=k.
- Accepted access by the owner with lock=0 clears locked. That access still completes.
- Reset values: locked=0, lock_owner=0.

Read return:
- rvalid[i] <= req[i]&&gnt[i]&&!we[i].
- rdata = mem_data_out, unregistered.
- Read latency is exactly 1 cycle.
- Writes produce no response.
- Back-to-back reads from any ports on consecutive cycles are supported at full throughput.

Reset:
- Asynchronous, active-low; asserting rst mid-operation clears rvalid, locked, rr_ptr and lock_abort immediately.
- An in-flight read's data is discarded (no rvalid after reset release).
- All outputs are 0 during reset.

Simultaneous events:
- Owner release and a new lock from another port in the same cycle cannot occur, since only the owner is granted.
- A single-port case (NUM_PORTS=2, only one requester) is granted every cycle.

Optional Feature:
LOCAL_MEM_ARB_LOCK_TIMEOUT_EN
- Defined:
  - lock_cnt (reset 0) increments each cycle while locked and clears when unlocked.
  - When lock_cnt reaches MAX_LOCK_CYCLES-1 and the owner makes no releasing access that cycle, locked clears, lock_abort[owner] pulses for 1 cycle, lock_cnt resets, and arbitration resumes round-robin next cycle.
  - An owner access in the timeout cycle is still accepted.
- Undefined: locks persist indefinitely; lock_abort tied to 0; no counter logic.

Test Plan:
- Ports 0 and 1 issue continuous reads (req=2'b11, addr0=0x10, addr1=0x20), rr_ptr=0 -> gnt alternates 01,10,01...; rvalid follows 1 cycle later; rdata matches mem[0x10]/mem[0x20].
- Port 1 writes be=4'b0011 wdata=0xAABBCCDD to addr 0x5, then port 0 reads 0x5 -> mem_be=0011 on the write cycle, 0000 on the read cycle; port 0 rdata low half =0xCCDD; rvalid[1] never set.
- Port 0 reads 0x8 with lock=1, port 1 requesting continuously -> gnt[1]=0 until port 0 writes 0x8 with lock=0; port 1 granted the cycle after.
- Assert rst low the cycle after a port 0 read accept -> rvalid[0] stays 0; gnt=0, mem_en=0 while low; rr_ptr=0 and locked=0 after release.
- With LOCAL_MEM_ARB_LOCK_TIMEOUT_EN, MAX_LOCK_CYCLES=16: port 0 locks then drops req -> lock_abort[0] pulses exactly 16 cycles after the lock accept; port 1 granted the next cycle.
- No requests for 10 cycles -> mem_en=0, gnt=0, rvalid=0 throughout; rr_ptr unchanged.

Source files
------------

// File: rtl/local_mem_arbiter_if.sv
// local_mem_arbiter_if: requester-side bus of the local memory arbiter, all ports packed per field.
interface local_mem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W = 30
);
    logic [NUM_PORTS-1:0] req, lock, we, gnt, rvalid, lock_abort;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*4-1:0] be;
    logic [NUM_PORTS*32-1:0] wdata;
    logic [31:0] rdata;
    modport master(output req, lock, we, addr, be, wdata, input gnt, rvalid, rdata, lock_abort);
    modport slave(input req, lock, we, addr, be, wdata, output gnt, rvalid, rdata, lock_abort);
endinterface

// File: rtl/local_mem_arbiter.sv
// local_mem_arbiter: round-robin, lockable arbiter sharing one single-port local memory.
// Define LOCAL_MEM_ARB_LOCK_TIMEOUT_EN to force-release locks after MAX_LOCK_CYCLES.
module local_mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W = 30,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    local_mem_arbiter_if.slave bus,
    output logic mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0] mem_be,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    localparam int PW = $clog2(NUM_PORTS);
    logic [PW-1:0] rr_ptr, owner, sel, cand, nxt_ptr;
    logic [NUM_PORTS-1:0] gnt_c, rvalid_q;
    logic locked, lock_set, lock_clr, abort;

    // Scan from the far end so the port closest to rr_ptr is written last and wins.
    always_comb begin
        gnt_c = '0;
        sel = '0;
        cand = '0;
        if (locked) begin
            if (bus.req[owner]) begin
                gnt_c[owner] = 1'b1;
                sel = owner;
            end
        end else
            for (int j = NUM_PORTS - 1; j >= 0; j--) begin
                cand = PW'((int'(rr_ptr) + j) % NUM_PORTS);
                if (bus.req[cand]) begin
                    gnt_c = '0;
                    gnt_c[cand] = 1'b1;
                    sel = cand;
                end
            end
    end

    assign bus.gnt = rst ? gnt_c : '0;
    assign mem_en = |bus.gnt;
    assign mem_addr = rst ? bus.addr[sel*ADDR_W +: ADDR_W] : '0;
    assign mem_be = (mem_en && bus.we[sel]) ? bus.be[sel*4 +: 4] : 4'h0;
    assign mem_data_in = rst ? bus.wdata[sel*32 +: 32] : '0;
    assign bus.rdata = rst ? mem_data_out : '0;
    assign bus.rvalid = rvalid_q;
    assign lock_set = mem_en && bus.lock[sel];
    assign lock_clr = mem_en && locked && !bus.lock[sel];
    assign nxt_ptr = (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rr_ptr <= '0;
            owner <= '0;
            locked <= 1'b0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= bus.gnt & ~bus.we;
            if (mem_en && !locked) rr_ptr <= nxt_ptr;
            if (abort || lock_clr) locked <= 1'b0;
            else if (lock_set) begin
                locked <= 1'b1;
                owner <= sel;
            end
        end

`ifdef LOCAL_MEM_ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(MAX_LOCK_CYCLES + 1);
    logic [CW-1:0] lock_cnt;
    // A releasing owner access in the last cycle wins over the timeout.
    assign abort = locked && lock_cnt == CW'(MAX_LOCK_CYCLES - 1) && !lock_clr;
    assign bus.lock_abort = abort ? NUM_PORTS'(1) << owner : '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) lock_cnt <= '0;
        else lock_cnt <= (locked && !abort && !lock_clr) ? lock_cnt + 1'b1 : '0;
`else
    assign abort = 1'b0;
    assign bus.lock_abort = '0;
`endif
endmodule

// File: tb/tb_local_mem_arbiter.sv
// tb_local_mem_arbiter: directed self-checking bench for local_mem_arbiter with a 1-cycle memory model.
module tb_local_mem_arbiter;
    logic clk, rst;
    logic mem_en;
    logic [29:0] mem_addr;
    logic [3:0] mem_be;
    logic [31:0] mem_data_in, mem_data_out;
    logic [31:0] mem [64];
    int errors = 0, checks = 0;
    logic [1:0] prev_g;
    logic [31:0] prev_d;

    local_mem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(30)) bus ();

    local_mem_arbiter #(.NUM_PORTS(2), .ADDR_W(30), .MAX_LOCK_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
            mem_data_out <= mem[mem_addr[5:0]];
        end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                         input logic [29:0] a0, input logic [29:0] a1);
        bus.req = r;
        bus.lock = l;
        bus.we = w;
        bus.addr = {a1, a0};
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h10] = 32'h1111_0010;
        mem[6'h20] = 32'h2222_0020;
        mem[6'h05] = 32'h1122_3344;
        mem_data_out = '0;
        rst = 1'b0;
        bus.be = {4'h3, 4'hF};
        bus.wdata = {32'hAABB_CCDD, 32'h5566_7788};
        drive(2'b11, 2'b00, 2'b00, 30'h10, 30'h20);
        tick;
        chk("rst_gnt", 64'(bus.gnt), 0);
        chk("rst_en", 64'(mem_en), 0);
        chk("rst_rvalid", 64'(bus.rvalid), 0);
        chk("rst_rdata", 64'(bus.rdata), 0);
        chk("rst_abort", 64'(bus.lock_abort), 0);
        rst = 1'b1;
        // Alternating continuous reads from both ports.
        prev_g = 2'b00;
        for (int c = 0; c < 5; c++) begin
            drive(c < 4 ? 2'b11 : 2'b00, 2'b00, 2'b00, 30'h10, 30'h20);
            chk("rr_gnt", 64'(bus.gnt), c == 4 ? 0 : (c % 2 ? 2 : 1));
            if (c < 4) chk("rr_addr", 64'(mem_addr), c % 2 ? 64'h20 : 64'h10);
            if (c > 0) begin
                chk("rr_rvalid", 64'(bus.rvalid), 64'(prev_g));
                chk("rr_rdata", 64'(bus.rdata), 64'(prev_d));
            end
            prev_g = c % 2 ? 2'b10 : 2'b01;
            prev_d = c % 2 ? 32'h2222_0020 : 32'h1111_0010;
            tick;
        end
        // Partial write by port 1 then read back by port 0.
        drive(2'b10, 2'b00, 2'b10, 30'h0, 30'h5);
        chk("wr_gnt", 64'(bus.gnt), 2);
        chk("wr_be", 64'(mem_be), 3);
        chk("wr_data", 64'(mem_data_in), 64'hAABB_CCDD);
        tick;
        drive(2'b01, 2'b00, 2'b00, 30'h5, 30'h0);
        chk("rd_gnt", 64'(bus.gnt), 1);
        chk("rd_be", 64'(mem_be), 0);
        chk("wr_norv", 64'(bus.rvalid), 0);
        tick;
        drive(2'b00, 2'b00, 2'b00, 30'h0, 30'h0);
        chk("rd_rvalid", 64'(bus.rvalid), 1);
        chk("rd_rdata", 64'(bus.rdata), 64'h1122_CCDD);
        tick;
        // Lock by port 0 blocks port 1 until released.
        drive(2'b01, 2'b01, 2'b00, 30'h8, 30'h0);
        chk("lk_gnt", 64'(bus.gnt), 1);
        tick;
        drive(2'b10, 2'b00, 2'b00, 30'h8, 30'h0);
        chk("lk_block", 64'(bus.gnt), 0);
        chk("lk_idle", 64'(mem_en), 0);
        chk("lk_rvalid", 64'(bus.rvalid), 1);
        chk("lk_noabort", 64'(bus.lock_abort), 0);
        tick;
        drive(2'b11, 2'b00, 2'b01, 30'h8, 30'h0);
        chk("lk_owner", 64'(bus.gnt), 1);
        chk("lk_wbe", 64'(mem_be), 64'hF);
        tick;
        drive(2'b10, 2'b00, 2'b00, 30'h0, 30'h0);
        chk("lk_release", 64'(bus.gnt), 2);
        tick;
        drive(2'b11, 2'b00, 2'b00, 30'h0, 30'h0);
        chk("lk_rr", 64'(bus.gnt), 1);
        tick;
        // Idle period leaves the pointer alone.
        for (int c = 0; c < 10; c++) begin
            drive(2'b00, 2'b00, 2'b00, 30'h0, 30'h0);
            chk("idle", {59'b0, mem_en, bus.gnt, bus.rvalid}, c == 0 ? 64'h1 : 64'h0);
            tick;
        end
        drive(2'b11, 2'b00, 2'b00, 30'h0, 30'h0);
        chk("idle_ptr", 64'(bus.gnt), 2);
        tick;
        // Reset right after a locked read accept.
        drive(2'b01, 2'b01, 2'b00, 30'h10, 30'h0);
        chk("mr_gnt", 64'(bus.gnt), 1);
        tick;
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 30'h10, 30'h0);
        chk("mr_rvalid", 64'(bus.rvalid), 0);
        chk("mr_gnt0", 64'(bus.gnt), 0);
        chk("mr_en0", 64'(mem_en), 0);
        tick;
        chk("mr_hold", {62'b0, mem_en, |bus.rvalid}, 0);
        tick;
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 30'h0, 30'h0);
        tick;
        chk("mr_norv", 64'(bus.rvalid), 0);
        drive(2'b10, 2'b00, 2'b00, 30'h0, 30'h0);
        chk("mr_unlocked", 64'(bus.gnt), 2);
        tick;
`ifdef LOCAL_MEM_ARB_LOCK_TIMEOUT_EN
        drive(2'b01, 2'b01, 2'b00, 30'h3, 30'h0);
        chk("to_lock", 64'(bus.gnt), 1);
        tick;
        for (int c = 1; c <= 17; c++) begin
            drive(2'b10, 2'b00, 2'b00, 30'h0, 30'h0);
            chk("to_abort", 64'(bus.lock_abort), c == 16 ? 1 : 0);
            chk("to_gnt", 64'(bus.gnt), c == 17 ? 2 : 0);
            tick;
        end
        drive(2'b00, 2'b00, 2'b00, 30'h0, 30'h0);
        chk("to_after", 64'(bus.lock_abort), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
